// File: rtl/exu_dispatch_q.sv
// In-order dispatch queue between decode and the execution units: buffers DEPTH
// decoded instructions and issues the head to the unit selected by its group code.
module exu_dispatch_q #(
  parameter int DEPTH   = 4,
  parameter int INFO_W  = 32,
  parameter int GRP_W   = 3,
  parameter int NUM_GRP = 6
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [INFO_W-1:0]          in_info_i,
  input  logic [31:0]                in_imm_i,
  input  logic [31:0]                in_pc_i,
  input  logic [31:0]                in_rs1_i,
  input  logic [31:0]                in_rs2_i,
  output logic [NUM_GRP-1:0]         disp_valid_o,
  input  logic [NUM_GRP-1:0]         disp_ready_i,
  output logic [INFO_W-1:0]          disp_info_o,
  output logic [31:0]                disp_imm_o,
  output logic [31:0]                disp_pc_o,
  output logic [31:0]                disp_rs1_o,
  output logic [31:0]                disp_rs2_o,
  output logic                       illegal_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INFO_W-1:0] infoMem_q [DEPTH];
  logic [31:0]       immMem_q  [DEPTH];
  logic [31:0]       pcMem_q   [DEPTH];
  logic [31:0]       rs1Mem_q  [DEPTH];
  logic [31:0]       rs2Mem_q  [DEPTH];

  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic              notEmpty;
  logic              grpLegal;
  logic [GRP_W-1:0]  headGrp;
  logic [NUM_GRP-1:0] dispValid;
  logic              push;
  logic              pop;

  assign notEmpty = (count_q != '0);
  assign headGrp  = infoMem_q[rp_q][GRP_W-1:0];
  assign grpLegal = (int'(headGrp) < NUM_GRP);

  always_comb begin
    dispValid = '0;
    for (int g = 0; g < NUM_GRP; g++) begin
      dispValid[g] = notEmpty && grpLegal && (int'(headGrp) == g);
    end
  end

  // An illegal head retires on its own so a bad group code can never wedge the queue.
  assign in_ready_o = (count_q < CNT_W'(DEPTH));
  assign push       = in_valid_i && in_ready_o && !flush_i;
  assign pop        = notEmpty && (grpLegal ? |(dispValid & disp_ready_i) : 1'b1);

  assign disp_valid_o = dispValid;
  assign illegal_o    = notEmpty && !grpLegal;
  assign disp_info_o  = notEmpty ? infoMem_q[rp_q] : '0;
  assign disp_imm_o   = notEmpty ? immMem_q[rp_q]  : '0;
  assign disp_pc_o    = notEmpty ? pcMem_q[rp_q]   : '0;
  assign disp_rs1_o   = notEmpty ? rs1Mem_q[rp_q]  : '0;
  assign disp_rs2_o   = notEmpty ? rs2Mem_q[rp_q]  : '0;
  assign count_o      = count_q;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush_i) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_W'(1);
      if (pop)  rp_d = rp_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (!push && pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      infoMem_q[wp_q] <= in_info_i;
      immMem_q[wp_q]  <= in_imm_i;
      pcMem_q[wp_q]   <= in_pc_i;
      rs1Mem_q[wp_q]  <= in_rs1_i;
      rs2Mem_q[wp_q]  <= in_rs2_i;
    end
  end

endmodule

// File: tb/tb_exu_dispatch_q.sv
// Bench for exu_dispatch_q: directed vectors checked against a queue-based model
// every cycle, plus literal expectations at the key points of each scenario.
module tb_exu_dispatch_q;

  localparam int DEPTH   = 4;
  localparam int NUM_GRP = 6;

  logic        clk;
  logic        rst;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_info_i;
  logic [31:0] in_imm_i;
  logic [31:0] in_pc_i;
  logic [31:0] in_rs1_i;
  logic [31:0] in_rs2_i;
  logic [5:0]  disp_valid_o;
  logic [5:0]  disp_ready_i;
  logic [31:0] disp_info_o;
  logic [31:0] disp_imm_o;
  logic [31:0] disp_pc_o;
  logic [31:0] disp_rs1_o;
  logic [31:0] disp_rs2_o;
  logic        illegal_o;
  logic [2:0]  count_o;

  int numChecks = 0;
  int numFails  = 0;

  typedef struct packed {
    logic [31:0] info;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } entry_t;

  entry_t modelQ[$];
  bit     modelLive = 0;

  exu_dispatch_q #(.DEPTH(DEPTH), .INFO_W(32), .GRP_W(3), .NUM_GRP(NUM_GRP)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_info_i    (in_info_i),
    .in_imm_i     (in_imm_i),
    .in_pc_i      (in_pc_i),
    .in_rs1_i     (in_rs1_i),
    .in_rs2_i     (in_rs2_i),
    .disp_valid_o (disp_valid_o),
    .disp_ready_i (disp_ready_i),
    .disp_info_o  (disp_info_o),
    .disp_imm_o   (disp_imm_o),
    .disp_pc_o    (disp_pc_o),
    .disp_rs1_o   (disp_rs1_o),
    .disp_rs2_o   (disp_rs2_o),
    .illegal_o    (illegal_o),
    .count_o      (count_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numChecks++;
    if (act !== exp) begin
      numFails++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of decode/unit inputs, then step past the clock edge.
  task automatic applyStimulus(input logic v, input logic [2:0] g, input int tag,
                               input logic [5:0] rdy, input logic fl);
    logic [31:0] t;
    t            = tag;
    in_valid_i   = v;
    in_info_i    = {t[28:0], g};
    in_imm_i     = t;
    in_pc_i      = 32'h80 + (t << 2);
    in_rs1_i     = ~t;
    in_rs2_i     = t ^ 32'hA5A5_A5A5;
    disp_ready_i = rdy;
    flush_i      = fl;
    @(posedge clk);
    #1;
  endtask

  // Model: a plain queue; the head is offered to unit grp and retires on its ready.
  always @(posedge clk) begin
    int  g;
    bit  popNow;
    bit  pushNow;
    if (rst) begin
      modelQ.delete();
      modelLive = 1;
    end else if (modelLive) begin
      if (flush_i) begin
        modelQ.delete();
      end else begin
        popNow = 0;
        if (modelQ.size() > 0) begin
          g = int'(modelQ[0].info[2:0]);
          popNow = (g >= NUM_GRP) ? 1'b1 : disp_ready_i[g];
        end
        pushNow = in_valid_i && (modelQ.size() < DEPTH);
        if (popNow) modelQ.delete(0);
        if (pushNow) modelQ.push_back({in_info_i, in_imm_i, in_pc_i, in_rs1_i, in_rs2_i});
      end
    end
  end

  always @(negedge clk) begin
    entry_t h;
    int     g;
    logic [5:0] expValid;
    logic   expIllegal;
    if (modelLive) begin
      h          = '0;
      expValid   = '0;
      expIllegal = 1'b0;
      if (modelQ.size() > 0) begin
        h = modelQ[0];
        g = int'(h.info[2:0]);
        if (g < NUM_GRP) expValid = 6'(1 << g);
        else             expIllegal = 1'b1;
      end
      checkOutput("count",      32'(count_o),      32'(modelQ.size()));
      checkOutput("in_ready",   32'(in_ready_o),   32'(modelQ.size() < DEPTH));
      checkOutput("disp_valid", 32'(disp_valid_o), 32'(expValid));
      checkOutput("illegal",    32'(illegal_o),    32'(expIllegal));
      checkOutput("disp_info",  disp_info_o,       h.info);
      checkOutput("disp_imm",   disp_imm_o,        h.imm);
      checkOutput("disp_pc",    disp_pc_o,         h.pc);
      checkOutput("disp_rs1",   disp_rs1_o,        h.rs1);
      checkOutput("disp_rs2",   disp_rs2_o,        h.rs2);
    end
  end

  initial begin
    rst = 1;
    applyStimulus(0, 0, 0, 6'h3F, 0);
    applyStimulus(0, 0, 0, 6'h3F, 0);
    rst = 0;
    checkOutput("lit_rst_count", 32'(count_o), 0);
    checkOutput("lit_rst_ready", 32'(in_ready_o), 1);
    checkOutput("lit_rst_valid", 32'(disp_valid_o), 0);
    checkOutput("lit_rst_pc", disp_pc_o, 0);

    // Single ALU op with every unit ready.
    applyStimulus(1, 0, 0, 6'h3F, 0);
    checkOutput("lit_alu_valid", 32'(disp_valid_o), 32'h01);
    checkOutput("lit_alu_pc", disp_pc_o, 32'h80);
    applyStimulus(0, 0, 0, 6'h3F, 0);
    checkOutput("lit_alu_count", 32'(count_o), 0);

    // MULDIV back-pressure fills the queue; the fifth offer is refused.
    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 2, i, 6'b111011, 0);
      if (i == 4) begin
        checkOutput("lit_full_ready", 32'(in_ready_o), 0);
        checkOutput("lit_full_count", 32'(count_o), 4);
      end
    end
    checkOutput("lit_full_hold", 32'(count_o), 4);
    for (int i = 1; i <= 4; i++) begin
      checkOutput("lit_drain_imm", disp_imm_o, 32'(i));
      applyStimulus(0, 0, 0, 6'h3F, 0);
    end
    checkOutput("lit_drain_count", 32'(count_o), 0);

    // Offer at full while the head pops: offer refused, space reappears next cycle.
    for (int i = 11; i <= 14; i++) applyStimulus(1, 2, i, 6'b111011, 0);
    applyStimulus(1, 2, 15, 6'h3F, 0);
    checkOutput("lit_fullpop_ready", 32'(in_ready_o), 1);
    checkOutput("lit_fullpop_count", 32'(count_o), 3);
    for (int i = 40; i < 50; i++) applyStimulus(1, 3'(i % 6), i, 6'h3F, 0);
    checkOutput("lit_wrap_count", 32'(count_o), 3);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 6'h3F, 0);
    checkOutput("lit_wrap_empty", 32'(count_o), 0);

    // Illegal group 7 is dropped in one cycle, then a CSR op issues.
    applyStimulus(1, 7, 20, 6'h3F, 0);
    checkOutput("lit_ill_flag", 32'(illegal_o), 1);
    checkOutput("lit_ill_valid", 32'(disp_valid_o), 0);
    applyStimulus(1, 3, 21, 6'h3F, 0);
    checkOutput("lit_csr_valid", 32'(disp_valid_o), 32'h08);
    checkOutput("lit_csr_ill", 32'(illegal_o), 0);
    applyStimulus(0, 0, 0, 6'h3F, 0);

    // Flush with a simultaneous push at count 3.
    for (int i = 30; i <= 32; i++) applyStimulus(1, 1, i, 6'h00, 0);
    checkOutput("lit_flush_pre", 32'(count_o), 3);
    applyStimulus(1, 1, 33, 6'h3F, 1);
    checkOutput("lit_flush_count", 32'(count_o), 0);
    checkOutput("lit_flush_valid", 32'(disp_valid_o), 0);
    applyStimulus(0, 0, 0, 6'h00, 0);
    checkOutput("lit_flush_after", 32'(count_o), 0);

    // Reset mid-stream at count 2.
    applyStimulus(1, 4, 60, 6'h00, 0);
    applyStimulus(1, 4, 61, 6'h00, 0);
    checkOutput("lit_mid_pre", 32'(count_o), 2);
    rst = 1;
    applyStimulus(0, 0, 0, 6'h00, 0);
    rst = 0;
    checkOutput("lit_mid_count", 32'(count_o), 0);
    checkOutput("lit_mid_ready", 32'(in_ready_o), 1);
    checkOutput("lit_mid_valid", 32'(disp_valid_o), 0);
    checkOutput("lit_mid_info", disp_info_o, 0);
    applyStimulus(0, 0, 0, 6'h3F, 0);
    applyStimulus(0, 0, 0, 6'h3F, 0);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule
